// File: rtl/shift_serializer_ctl.sv
// Serializer around a universal shift register: N-bit word in over load_valid/ready,
// N/S beats of S bits out over so_valid/ready. Optional rotate fill: SHIFT_ROTATE_EN.
module shift_serializer_ctl #(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  input  logic         load_dir,
  input  logic         load_rot,
  input  logic [S-1:0] si,
  output logic [S-1:0] so,
  output logic         so_valid,
  input  logic         so_ready,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         state_dbg
);

  localparam int BEATS = N / S;
  localparam int CNT_W = $clog2(BEATS + 1);

  if (N < 2 || S < 1 || S > N || (N % S) != 0) begin : g_bad_param
    $error("shift_serializer_ctl: need N >= 2, 1 <= S <= N and N %% S == 0");
  end

  // Handshakes: a load transfers on a rising edge where load_valid && load_ready;
  // a beat transfers on a rising edge where so_valid && so_ready. Both ready/valid
  // outputs depend only on registered state.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_q, w_q_nxt;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             w_rot;
  logic             w_load;
  logic             w_beat;
  logic [S-1:0]     w_so;
  logic [S-1:0]     w_fill;

  assign w_load = (r_state == ST_IDLE) && load_valid;
  assign w_beat = (r_state == ST_SHIFT) && so_ready;

`ifdef SHIFT_ROTATE_EN
  logic r_rot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rot <= 1'b0;
    end else if (w_load) begin
      r_rot <= load_rot;
    end
  end

  assign w_rot = r_rot;
`else
  logic w_unused_rot;

  assign w_unused_rot = load_rot;
  assign w_rot        = 1'b0;
`endif

  // The outgoing slice is also the rotate fill, so a rotate transfer restores the word.
  assign w_so   = r_dir ? r_q[N-1 -: S] : r_q[S-1:0];
  assign w_fill = w_rot ? w_so : si;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_q_nxt     = load_data;
          w_dir_nxt   = load_dir;
          w_cnt_nxt   = CNT_W'(BEATS);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_beat) begin
          // Shift amounts of S == N clear the old word entirely, leaving only the fill.
          w_q_nxt   = r_dir ? ((r_q << S) | N'(w_fill))
                            : ((r_q >> S) | (N'(w_fill) << (N - S)));
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign load_ready = (r_state == ST_IDLE);
  assign so_valid   = (r_state == ST_SHIFT);
  assign busy       = (r_state == ST_SHIFT);
  assign so         = w_so;
  assign q          = r_q;
  assign done       = r_done;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_shift_serializer_ctl.sv
// Bench for shift_serializer_ctl: scoreboarded N=8/S=1 instance with random traffic,
// plus directed N=8/S=2 and N=4/S=4 instances.
`timescale 1ns/1ps
module tb_shift_serializer_ctl;

  localparam int N     = 8;
  localparam int S     = 1;
  localparam int BEATS = N / S;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (N=8, S=1) ----------------
  logic         load_valid, load_ready, load_dir, load_rot;
  logic [N-1:0] load_data, q;
  logic [S-1:0] si, so;
  logic         so_valid, so_ready, busy, done, state_dbg;

  shift_serializer_ctl #(.N(N), .S(S)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_dir(load_dir), .load_rot(load_rot), .si(si),
    .so(so), .so_valid(so_valid), .so_ready(so_ready),
    .q(q), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- N=8, S=2 DUT ----------------
  logic       load_valid2, load_ready2, load_dir2, load_rot2;
  logic [7:0] load_data2, q2;
  logic [1:0] si2, so2;
  logic       so_valid2, so_ready2, busy2, done2, state_dbg2;

  shift_serializer_ctl #(.N(8), .S(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid2), .load_ready(load_ready2), .load_data(load_data2),
    .load_dir(load_dir2), .load_rot(load_rot2), .si(si2),
    .so(so2), .so_valid(so_valid2), .so_ready(so_ready2),
    .q(q2), .busy(busy2), .done(done2), .state_dbg(state_dbg2)
  );

  // ---------------- N=4, S=4 DUT ----------------
  logic       load_valid4, load_ready4, load_dir4, load_rot4;
  logic [3:0] load_data4, q4, si4, so4;
  logic       so_valid4, so_ready4, busy4, done4, state_dbg4;

  shift_serializer_ctl #(.N(4), .S(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid4), .load_ready(load_ready4), .load_data(load_data4),
    .load_dir(load_dir4), .load_rot(load_rot4), .si(si4),
    .so(so4), .so_valid(so_valid4), .so_ready(so_ready4),
    .q(q4), .busy(busy4), .done(done4), .state_dbg(state_dbg4)
  );

  // ---------------- checking core ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (main DUT) ----------------
  logic [S-1:0] exp_q[$];
  logic [N-1:0] exp_word_q[$];
  logic         exp_dir_q[$];
  logic         exp_rot_q[$];
  logic [S-1:0] si_hist[$];
  int           beats_seen = 0;
  logic         pend_done  = 1'b0;
  logic [N-1:0] mon_word, mon_eq;
  logic         mon_dir, mon_rot, in_flight;

  // Every beat drains the original word, so the stream is just the word sliced in
  // beat order; the final q is the word (rotate) or the recorded fills in place.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_word_q.delete();
      exp_dir_q.delete();
      exp_rot_q.delete();
      si_hist.delete();
      beats_seen = 0;
      pend_done  = 1'b0;
    end else begin
      check("done", 32'(done), 32'(pend_done));
      if (pend_done) begin
        mon_word = exp_word_q.pop_front();
        mon_dir  = exp_dir_q.pop_front();
        mon_rot  = exp_rot_q.pop_front();
        mon_eq   = '0;
        if (mon_rot && ROT_EN) begin
          mon_eq = mon_word;
        end else begin
          for (int i = 0; i < si_hist.size(); i++) begin
            if (mon_dir) mon_eq[(BEATS-1-i)*S +: S] = si_hist[i];
            else         mon_eq[i*S +: S]           = si_hist[i];
          end
        end
        check("final_q", 32'(q), 32'(mon_eq));
        si_hist.delete();
        beats_seen = 0;
      end
      pend_done = 1'b0;
      in_flight = (exp_q.size() != 0);
      check("so_valid", 32'(so_valid), 32'(in_flight));
      check("busy", 32'(busy), 32'(in_flight));
      check("load_ready", 32'(load_ready), 32'(!in_flight));
      if (in_flight) begin
        check("so", 32'(so), 32'(exp_q[0]));
        if (so_ready) begin
          void'(exp_q.pop_front());
          si_hist.push_back(si);
          beats_seen++;
          if (beats_seen == BEATS) pend_done = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_mode = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        si       = S'($urandom_range(0, (1 << S) - 1));
        so_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_word(input logic [N-1:0] w, input logic d, input logic r);
    int t;
    t          = 0;
    load_data  = w;
    load_dir   = d;
    load_rot   = r;
    load_valid = 1'b1;
    while (!load_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!load_ready) begin
      check("load_timeout", 32'(load_ready), 32'd1);
      load_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back(d ? w[N-S-k*S +: S] : w[k*S +: S]);
    end
    exp_word_q.push_back(w);
    exp_dir_q.push_back(d);
    exp_rot_q.push_back(r);
    check("first_beat_valid", 32'(so_valid), 32'd1);
    check("load_q", 32'(q), 32'(w));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !load_ready) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_dut2(input logic [7:0] w, input logic d, input logic r, input logic [1:0] s_in);
    logic [7:0] eq;
    eq          = (r && ROT_EN) ? w : {4{s_in}};
    load_data2  = w;
    load_dir2   = d;
    load_rot2   = r;
    si2         = s_in;
    so_ready2   = 1'b1;
    load_valid2 = 1'b1;
    check("dut2_ready", 32'(load_ready2), 32'd1);
    @(posedge clk);
    #1;
    load_valid2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("dut2_so_valid", 32'(so_valid2), 32'd1);
      check("dut2_so", 32'(so2), 32'(d ? w[6-2*k +: 2] : w[2*k +: 2]));
      @(posedge clk);
      #1;
    end
    check("dut2_done", 32'(done2), 32'd1);
    check("dut2_q", 32'(q2), 32'(eq));
    check("dut2_idle", 32'(load_ready2), 32'd1);
    @(posedge clk);
    #1;
    check("dut2_done_clear", 32'(done2), 32'd0);
  endtask

  task automatic run_dut4(input logic [3:0] w, input logic r, input logic [3:0] s_in);
    load_data4  = w;
    load_dir4   = 1'($urandom_range(0, 1));
    load_rot4   = r;
    si4         = s_in;
    so_ready4   = 1'b1;
    load_valid4 = 1'b1;
    @(posedge clk);
    #1;
    load_valid4 = 1'b0;
    check("dut4_so_valid", 32'(so_valid4), 32'd1);
    check("dut4_so", 32'(so4), 32'(w));
    check("dut4_done_early", 32'(done4), 32'd0);
    @(posedge clk);
    #1;
    check("dut4_done", 32'(done4), 32'd1);
    check("dut4_q", 32'(q4), 32'((r && ROT_EN) ? w : s_in));
    check("dut4_idle", 32'(load_ready4), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    load_valid  = 1'b0; load_data  = '0; load_dir  = 1'b0; load_rot  = 1'b0;
    si          = '0;   so_ready   = 1'b1;
    load_valid2 = 1'b0; load_data2 = '0; load_dir2 = 1'b0; load_rot2 = 1'b0;
    si2         = '0;   so_ready2  = 1'b1;
    load_valid4 = 1'b0; load_data4 = '0; load_dir4 = 1'b0; load_rot4 = 1'b0;
    si4         = '0;   so_ready4  = 1'b1;

    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_so", 32'(so), 32'd0);
    check("rst_so_valid", 32'(so_valid), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // LSB-first fill from si=1: beats 0,0,1,0,1,1,0,1 then q=FF
    si = 1'b1;
    send_word(8'hB4, 1'b0, 1'b0);
    wait_drain();

    // Backpressure after beat 2 for three cycles
    si = 1'b0;
    send_word(8'hB4, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    so_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    so_ready = 1'b1;
    wait_drain();

    // Load held at FF through SHIFT is ignored; 5A loaded in the done cycle
    send_word(8'hB4, 1'b1, 1'b1);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int t = 0; t < 20 && !load_ready; t++) begin
      @(posedge clk);
      #1;
    end
    check("done_cycle_load", 32'(done), 32'd1);
    send_word(8'h5A, 1'b0, 1'b1);
    wait_drain();

    // Reset while beat 4 is on so
    send_word(8'hB4, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_so_valid", 32'(so_valid), 32'd0);
    check("abort_load_ready", 32'(load_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    si = 1'b1;
    send_word(8'h3C, 1'b1, 1'b0);
    wait_drain();

    // Random traffic with random backpressure, si, direction and fill mode
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_word(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();
    rand_mode = 1'b0;
    so_ready  = 1'b1;

    // N=8, S=2: MSB-first B4 gives beats 2,3,1,0
    run_dut2(8'hB4, 1'b1, 1'b1, 2'b00);
    run_dut2(8'hB4, 1'b1, 1'b0, 2'b00);
    run_dut2(8'h6D, 1'b0, 1'b0, 2'b10);
    run_dut2(8'hC5, 1'b0, 1'b1, 2'b01);

    // N=4, S=4: a single beat per word
    run_dut4(4'h9, 1'b0, 4'h6);
    run_dut4(4'hA, 1'b1, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_serializer_ctl.md
# shift_serializer_ctl

Parametrised serializer built around a universal shift register. It accepts an N-bit word over a valid/ready load port and emits it as N/S beats of S bits each over a valid/ready serial port. Shift direction is selected per word (LSB-first or MSB-first), and vacated bits are filled from a serial input or by rotation. It sits between parallel datapaths and bit/nibble-serial links and replaces the fixed 1-bit right-shift loadable register for transmit paths that need flow control.

## Interface
- N, 8, register width in bits; N ≥ 2.
- S, 1, bits per beat; 1 ≤ S ≤ N, N % S == 0 (elaboration error otherwise).
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a word; high exactly in IDLE.
- load_data  input  N  word to serialize.
- load_dir  input  1  0 = LSB-first (shift right), 1 = MSB-first (shift left); sampled with the load.
- load_rot  input  1  1 = rotate (fill from outgoing bits), 0 = fill from si; sampled with the load.
- si  input  S  serial fill bits, sampled on each accepted beat.
- so  output  S  current beat: q[S-1:0] if dir=0, q[N-1:N-S] if dir=1.
- so_valid  output  1  beat on so is valid; high exactly in SHIFT.
- so_ready  input  1  consumer accepts beat.
- q  output  N  register contents.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse after final beat accepted.

## Operation
- States: IDLE, SHIFT. Registered state: q, dir, rot, beat counter cnt (width $clog2(N/S+1)), done.
- IDLE: load_ready=1. On load_valid, q←load_data, dir←load_dir, rot←load_rot, cnt←N/S, state←SHIFT. Without load_valid: hold.
- SHIFT: so_valid=1, load_ready=0, load_valid ignored. On so_valid && so_ready (a beat):
  - dir=0: q←{fill, q[N-1:S]}; dir=1: q←{q[N-S-1:0], fill} (for S==N, q←fill).
  - fill = outgoing S bits if rot, else si.
  - cnt←cnt-1; if cnt==1, then state←IDLE and done←1 next cycle.
- so_ready low in SHIFT: q, cnt, and so stay stable (no beat lost or duplicated).
- done is 0 in every cycle except the one immediately after the final beat.
- After a rotate transfer, q equals the original word. After a fill transfer, q holds the last N/S si values.

## Timing
- Reset (asynchronous, immediate): q=0, cnt=0, dir=0, rot=0, state=IDLE, done=0. During and after reset: load_ready=1, so_valid=0, busy=0, so=0.
- Reset asserted mid-transfer aborts it. Partial beats are not resumed.
- Load accepted at edge E0; so_valid=1 and the first beat is on so in the cycle after E0.
- With so_ready held high, beat k is accepted at edge E0+k, for k=1..N/S.
- done=1 and load_ready=1 in the cycle after the final beat. A load presented in that cycle is accepted, giving a throughput of N/S+1 cycles per word.
- N/S==1: a single beat; done follows the first accepted beat.
- so, so_valid, load_ready and busy are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- SHIFT_ROTATE_EN defined: load_rot is honoured as described above.
- SHIFT_ROTATE_EN undefined: rot is tied to 0, load_rot is ignored, fill is always si, and no rot flop is built.

## Test plan
- N=8,S=1, load 0xB4 dir=0 rot=0, si=1, so_ready=1 → so = 0,0,1,0,1,1,0,1 on cycles 1–8; done in cycle 9; q=0xFF.
- N=8,S=2, load 0xB4 dir=1 rot=1 → so = 2,3,1,0; done after the 4th beat; q=0xB4 (requires SHIFT_ROTATE_EN). Without the macro, same stimulus with si=0 → q=0x00.
- Backpressure: N=8,S=1, 0xB4 dir=0; drop so_ready for 3 cycles after beat 2 → so holds 1 and q is unchanged; the sequence resumes intact with 8 beats total.
- load_valid=1 with data 0xFF throughout SHIFT → ignored, load_ready=0; loading 0x5A in the done cycle is accepted and its first beat appears next cycle.
- Assert reset_n low at beat 4 → q=0, so_valid=0, load_ready=1, done=0 immediately; the next load serializes correctly from beat 1.
- N=4,S=4, load 0x9 → one beat so=0x9; done the next cycle.
